// File: rtl/mem_stage_pkg.sv
// Shared decode constants, exception codes and FSM state type for the memory stage.
// Optional store-to-load forwarding is enabled with the STORE_FWD_EN macro.
package mem_stage_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_MULT = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   localparam logic [31:0] EXC_ADD  = 32'd1;
   localparam logic [31:0] EXC_ADDI = 32'd2;
   localparam logic [31:0] EXC_SUB  = 32'd3;
   localparam logic [31:0] EXC_MULT = 32'd4;
   localparam logic [31:0] EXC_DIV  = 32'd5;

   typedef enum logic [1:0] {IDLE, DRAIN, LOAD} mem_state_e;

   // rstatus code for an instruction; zero when no exception is reported
   function automatic logic [31:0] exc_code(input logic [4:0] opcode, input logic [4:0] alu_op,
                                            input logic exception);
      logic [31:0] code;
      code = '0;
      if (exception) begin
         if (opcode == OP_RTYPE) begin
            case (alu_op)
               ALU_ADD:  code = EXC_ADD;
               ALU_SUB:  code = EXC_SUB;
               ALU_MULT: code = EXC_MULT;
               ALU_DIV:  code = EXC_DIV;
               default:  code = '0;
            endcase
         end else if (opcode == OP_ADDI) begin
            code = EXC_ADDI;
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/mem_stage_unit_store_buffer_fifo.sv
// Store buffer: circular FIFO of {address, data} pairs drained oldest first.
// With STORE_FWD_EN defined, a lookup port reports the newest valid entry
// whose address matches.
module store_buffer_fifo
   import mem_stage_pkg::*;
#(
   parameter int  DATA_W   = 32,
   parameter int  ADDR_W   = 12,
   parameter int  SB_DEPTH = 4,
   localparam int PW       = $clog2(SB_DEPTH),
   localparam int CW       = PW + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
`ifdef STORE_FWD_EN
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              lookup_hit,
   output logic [DATA_W-1:0] lookup_data,
`endif
   output logic [CW-1:0]     count
);

   logic [ADDR_W-1:0] addr_q [SB_DEPTH];
   logic [DATA_W-1:0] data_q [SB_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   // entry payload is only meaningful below count, so it needs no reset
   always_ff @(posedge clock) begin
      if (push) begin
         addr_q[wr_ptr] <= push_addr;
         data_q[wr_ptr] <= push_data;
      end
   end

   // pointers and occupancy; a simultaneous push and pop leave the count unchanged
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];

`ifdef STORE_FWD_EN
   // scan oldest to newest so the youngest matching store ends up selected
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if ((CW'(i) < count) && (addr_q[rd_ptr + PW'(i)] == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = data_q[rd_ptr + PW'(i)];
         end
      end
   end
`endif

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage between execute and writeback: buffers stores, drains them over
// a req/ack port, issues loads, and registers the writeback bundle.
// STORE_FWD_EN enables store-to-load forwarding from the store buffer.
//
//   state | meaning
//   IDLE  | no request outstanding; picks a load (priority) or a drain
//   DRAIN | writing the store-buffer head, waiting for mem_ack
//   LOAD  | reading the pending load address, waiting for mem_ack
module mem_stage_unit
   import mem_stage_pkg::*;
#(
   parameter int  DATA_W   = 32,
   parameter int  ADDR_W   = 12,
   parameter int  SB_DEPTH = 4,
   localparam int CW       = $clog2(SB_DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       insn,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic              exception,
   output logic              out_valid,
   output logic [31:0]       out_insn,
   output logic [DATA_W-1:0] out_data,
   output logic [31:0]       out_exc_data,
   output logic              out_exc_we,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CW-1:0]     sb_count
);

   mem_state_e        state, state_nxt;
   logic              fire, is_sw, is_lw, push, pop, load_done, load_may_issue;
   logic              load_pending;
   logic [ADDR_W-1:0] eff_addr, ld_addr, head_addr;
   logic [DATA_W-1:0] head_data;
   logic [31:0]       ld_insn, exc_now;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   assign eff_addr = alu_result[ADDR_W-1:0];
   assign is_sw    = (insn[31:27] == OP_SW);
   assign is_lw    = (insn[31:27] == OP_LW);
   assign in_ready = !load_pending && (sb_count < CW'(SB_DEPTH));
   assign fire     = in_valid && in_ready;
   assign push     = fire && is_sw;
   assign exc_now  = exc_code(insn[31:27], insn[6:2], exception);

   store_buffer_fifo #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .SB_DEPTH (SB_DEPTH)
   ) u_sb (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .push_addr   (eff_addr),
      .push_data   (store_data),
      .pop         (pop),
      .head_addr   (head_addr),
      .head_data   (head_data),
`ifdef STORE_FWD_EN
      .lookup_addr (eff_addr),
      .lookup_hit  (fwd_hit),
      .lookup_data (fwd_data),
`endif
      .count       (sb_count)
   );

`ifdef STORE_FWD_EN
   // an unmatched load cannot alias anything in the buffer, so it need not wait
   assign load_may_issue = load_pending;
`else
   assign fwd_hit        = 1'b0;
   assign fwd_data       = '0;
   assign load_may_issue = load_pending && (sb_count == '0);
`endif

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state; pop and load completion happen on the acked cycle
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load_done = 1'b0;
      case (state)
         IDLE: begin
            if (load_may_issue)       state_nxt = LOAD;
            else if (sb_count != '0)  state_nxt = DRAIN;
         end
         DRAIN: begin
            if (mem_ack) begin
               pop       = 1'b1;
               state_nxt = IDLE;
            end
         end
         LOAD: begin
            if (mem_ack) begin
               load_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // memory port registers: loaded when leaving IDLE, held until the ack
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (state == IDLE && state_nxt == LOAD) begin
         mem_req  <= 1'b1;
         mem_we   <= 1'b0;
         mem_addr <= ld_addr;
      end else if (state == IDLE && state_nxt == DRAIN) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b1;
         mem_addr  <= head_addr;
         mem_wdata <= head_data;
      end else if (pop || load_done) begin
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
      end
   end

   // pending load capture and writeback bundle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         load_pending <= 1'b0;
         ld_addr      <= '0;
         ld_insn      <= '0;
         out_valid    <= 1'b0;
         out_insn     <= '0;
         out_data     <= '0;
         out_exc_data <= '0;
         out_exc_we   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (load_done) begin
            load_pending <= 1'b0;
            out_valid    <= 1'b1;
            out_insn     <= ld_insn;
            out_data     <= mem_rdata;
            out_exc_data <= '0;
            out_exc_we   <= 1'b0;
         end else if (fire) begin
            if (is_lw && !fwd_hit) begin
               load_pending <= 1'b1;
               ld_addr      <= eff_addr;
               ld_insn      <= insn;
            end else begin
               out_valid    <= 1'b1;
               out_insn     <= insn;
               out_data     <= is_lw ? fwd_data : alu_result;
               out_exc_data <= exc_now;
               out_exc_we   <= (exc_now != '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed steps followed by random
// traffic, checked against a program-order memory model and writeback queue.
`timescale 1ns/1ps
module tb_mem_stage_unit;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 12;
   localparam int SB_DEPTH = 4;
   localparam int CW       = $clog2(SB_DEPTH) + 1;
   localparam logic [4:0] T_R = 5'b00000, T_ADDI = 5'b00101, T_SW = 5'b00111, T_LW = 5'b01000;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid, in_ready, exception;
   logic [31:0]       insn;
   logic [DATA_W-1:0] alu_result, store_data;
   logic              out_valid, out_exc_we;
   logic [31:0]       out_insn, out_exc_data;
   logic [DATA_W-1:0] out_data;
   logic              mem_req, mem_we, mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic [CW-1:0]     sb_count;

   always #5 clock = ~clock;

   mem_stage_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .insn(insn), .alu_result(alu_result), .store_data(store_data), .exception(exception),
      .out_valid(out_valid), .out_insn(out_insn), .out_data(out_data),
      .out_exc_data(out_exc_data), .out_exc_we(out_exc_we),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .sb_count(sb_count));

   typedef struct { logic [31:0] insn; logic [DATA_W-1:0] data; logic [31:0] exc; } wb_t;
   typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } st_t;

   int                n_chk = 0, n_fail = 0, n_reads = 0;
   logic [DATA_W-1:0] mem_model [1<<ADDR_W];
   logic [DATA_W-1:0] ref_mem   [1<<ADDR_W];
   wb_t               exp_wb[$];
   st_t               exp_st[$];
   bit                auto_ack = 1'b0, manual_ack = 1'b0;
   int                ack_lat = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_exc(input logic [31:0] i, input logic e);
      if (!e) return 32'd0;
      if (i[31:27] == T_R) begin
         if (i[6:2] == 5'd0) return 32'd1;
         if (i[6:2] == 5'd1) return 32'd3;
         if (i[6:2] == 5'd6) return 32'd4;
         if (i[6:2] == 5'd7) return 32'd5;
         return 32'd0;
      end
      if (i[31:27] == T_ADDI) return 32'd2;
      return 32'd0;
   endfunction

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] aop);
      return {op, 20'($urandom), aop, 2'($urandom)};
   endfunction

   // architectural effect of an accepted instruction, in program order
   task automatic model_accept(input logic [31:0] i, input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] sd, input logic e);
      wb_t w;
      st_t s;
      logic [ADDR_W-1:0] ad;
      ad     = a[ADDR_W-1:0];
      w.insn = i;
      w.exc  = ref_exc(i, e);
      w.data = a;
      if (i[31:27] == T_SW) begin
         s.addr = ad;
         s.data = sd;
         exp_st.push_back(s);
         ref_mem[ad] = sd;
      end else if (i[31:27] == T_LW) begin
         w.data = ref_mem[ad];
      end
      exp_wb.push_back(w);
   endtask

   task automatic send(input logic [31:0] i, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] sd, input logic e);
      bit done;
      done = 1'b0;
      insn = i; alu_result = a; store_data = sd; exception = e; in_valid = 1'b1;
      for (int c = 0; c < 300 && !done; c++) begin
         if (in_ready === 1'b1) done = 1'b1;
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      check("send_accepted", done, 1'b1);
      if (done) model_accept(i, a, sd, e);
   endtask

   task automatic wait_quiet(input string tag);
      int c;
      c = 0;
      while ((exp_wb.size() != 0 || sb_count != '0 || mem_req !== 1'b0) && c < 1000) begin
         @(posedge clock); #1;
         c++;
      end
      check(tag, c < 1000, 1'b1);
   endtask

   task automatic exc_step(input string tag, input logic [4:0] op, input logic [4:0] aop,
                           input logic e, input int exp);
      send(mk(op, aop), $urandom, $urandom, e);
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_code"}, out_exc_data, exp);
      check({tag, "_we"}, out_exc_we, exp != 0);
   endtask

   // memory responder: acks after ack_lat extra cycles, or when forced by manual_ack
   initial begin
      int cnt;
      st_t s;
      cnt = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clock); #2;
         mem_ack = 1'b0;
         if (mem_req === 1'b1 && !reset) cnt++; else cnt = 0;
         if (manual_ack || (auto_ack && mem_req === 1'b1 && !reset && cnt > ack_lat)) begin
            mem_ack = 1'b1;
            if (mem_req === 1'b1 && mem_we === 1'b1) begin
               mem_model[mem_addr] = mem_wdata;
               check("write_expected", exp_st.size() > 0, 1'b1);
               if (exp_st.size() > 0) begin
                  s = exp_st.pop_front();
                  check("write_addr_order", mem_addr, s.addr);
                  check("write_data_order", mem_wdata, s.data);
               end
            end else if (mem_req === 1'b1) begin
               mem_rdata = mem_model[mem_addr];
               n_reads++;
`ifndef STORE_FWD_EN
               check("load_after_drain", sb_count, 0);
`endif
            end
         end
      end
   end

   // writeback monitor
   initial begin
      wb_t w;
      forever begin
         @(posedge clock); #3;
         if (out_valid !== 1'b0) begin
            check("wb_expected", exp_wb.size() > 0, 1'b1);
            if (exp_wb.size() > 0) begin
               w = exp_wb.pop_front();
               check("wb_insn", out_insn, w.insn);
               check("wb_data", out_data, w.data);
               check("wb_exc_data", out_exc_data, w.exc);
               check("wb_exc_we", out_exc_we, w.exc != 0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [ADDR_W-1:0] a0;
      int                reads0, c;
      in_valid = 1'b0; insn = '0; alu_result = '0; store_data = '0; exception = 1'b0;
      for (int k = 0; k < (1 << ADDR_W); k++) begin
         mem_model[k] = $urandom;
         ref_mem[k]   = mem_model[k];
      end

      // reset values
      repeat (3) @(posedge clock);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_sb_count", sb_count, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_exc_we", out_exc_we, 1'b0);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_in_ready", in_ready, 1'b1);

      // exception codes
      exc_step("add_exc", T_R, 5'd0, 1'b1, 1);
      @(posedge clock); #1;
      check("add_valid_one_cycle", out_valid, 1'b0);
      exc_step("addi_exc", T_ADDI, 5'($urandom), 1'b1, 2);
      exc_step("sub_exc", T_R, 5'd1, 1'b1, 3);
      exc_step("mult_exc", T_R, 5'd6, 1'b1, 4);
      exc_step("div_exc", T_R, 5'd7, 1'b1, 5);
      exc_step("rother_exc", T_R, 5'd2, 1'b1, 0);
      exc_step("add_noexc", T_R, 5'd0, 1'b0, 0);
      exc_step("other_exc", 5'd3, 5'd0, 1'b1, 0);

      // fill the buffer with no acks, then release one entry
      auto_ack = 1'b0;
      for (int k = 0; k < 4; k++)
         send(mk(T_SW, 5'($urandom)), {20'($urandom), 12'(12'h100 + 4 * k)}, $urandom, 1'b0);
      check("full_sb_count", sb_count, 4);
      check("full_in_ready", in_ready, 1'b0);
      check("full_mem_req", mem_req, 1'b1);
      check("full_mem_we", mem_we, 1'b1);
      check("full_mem_addr", mem_addr, 12'h100);
      manual_ack = 1'b1;
      @(posedge clock); #1;
      manual_ack = 1'b0;
      check("pop_sb_count", sb_count, 3);
      check("pop_in_ready", in_ready, 1'b1);
      auto_ack = 1'b1;
      ack_lat = 2;
      wait_quiet("drain_quiet");

      // store then load to the same address, ack latency 3
      ack_lat = 3;
      reads0 = n_reads;
      send(mk(T_SW, 5'd0), 32'h0000_0010, 32'h0000_AAAA, 1'b0);
      send(mk(T_LW, 5'd0), 32'h0000_0010, $urandom, 1'b0);
`ifdef STORE_FWD_EN
      check("fwd_valid", out_valid, 1'b1);
      check("fwd_data", out_data, 32'h0000_AAAA);
      wait_quiet("fwd_quiet");
      check("fwd_no_read", n_reads, reads0);
`else
      check("nofwd_waits", out_valid, 1'b0);
      wait_quiet("nofwd_quiet");
      check("nofwd_one_read", n_reads, reads0 + 1);
      check("nofwd_data", out_data, 32'h0000_AAAA);
`endif

      // two stores to one address; the load must see the newer one
      ack_lat = 5;
      send(mk(T_SW, 5'd0), 32'h0000_0020, 32'd1, 1'b0);
      send(mk(T_SW, 5'd0), 32'h0000_0020, 32'd2, 1'b0);
      send(mk(T_LW, 5'd0), 32'h0000_0020, $urandom, 1'b0);
`ifdef STORE_FWD_EN
      check("newest_valid", out_valid, 1'b1);
      check("newest_data", out_data, 32'd2);
`endif
      wait_quiet("newest_quiet");
      check("newest_final_data", out_data, 32'd2);

      // load held without ack for 10 cycles
      auto_ack = 1'b0;
      a0 = 12'h3C5;
      send(mk(T_LW, 5'd0), {20'($urandom), a0}, $urandom, 1'b0);
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); #1;
         check("held_in_ready", in_ready, 1'b0);
         check("held_no_valid", out_valid, 1'b0);
         check("held_mem_req", mem_req, 1'b1);
         check("held_mem_addr", mem_addr, a0);
         check("held_mem_we", mem_we, 1'b0);
      end
      manual_ack = 1'b1;
      @(posedge clock); #1;
      manual_ack = 1'b0;
      check("held_ret_valid", out_valid, 1'b1);
      check("held_ret_data", out_data, ref_mem[a0]);
      @(posedge clock); #1;
      check("held_ret_one_cycle", out_valid, 1'b0);

      // reset while a load is outstanding
      send(mk(T_LW, 5'd0), 32'h0000_0ABC, $urandom, 1'b0);
      c = 0;
      while (mem_req !== 1'b1 && c < 20) begin
         @(posedge clock); #1;
         c++;
      end
      check("rst_load_issued", mem_req, 1'b1);
      reset = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_mem_req", mem_req, 1'b0);
      check("arst_mem_addr", mem_addr, 0);
      check("arst_out_data", out_data, 0);
      check("arst_out_insn", out_insn, 0);
      check("arst_sb_count", sb_count, 0);
      check("arst_in_ready", in_ready, 1'b1);
      exp_wb.delete();
      exp_st.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      manual_ack = 1'b1;
      @(posedge clock); #1;
      manual_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clock); #1;
         check("post_rst_no_valid", out_valid, 1'b0);
         check("post_rst_no_req", mem_req, 1'b0);
      end

      // random traffic over a small address window
      auto_ack = 1'b1;
      for (int n = 0; n < 200; n++) begin
         int          r;
         logic [4:0]  op;
         if (n % 25 == 0) ack_lat = $urandom_range(0, 4);
         r  = $urandom_range(0, 9);
         op = (r < 3) ? T_R : (r < 4) ? T_ADDI : (r < 7) ? T_SW : (r < 9) ? T_LW : 5'd2;
         send(mk(op, 5'($urandom_range(0, 7))), {20'($urandom), 9'h008, 3'($urandom)},
              $urandom, 1'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clock); #1;
         end
      end
      wait_quiet("rand_quiet");
      for (int k = 0; k < 8; k++)
         check("rand_mem", mem_model[12'h040 + k], ref_mem[12'h040 + k]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
